modular_multiply: RTL
=====================

# modular_multiply

Sequential interleaved modular multiplier computing (a·b) mod n one multiplier bit per clock, MSB first. It is the forward companion to `modular_inverse`: it checks inverse results in the RSA datapath (a·a⁻¹ mod n = 1) and performs the modular products for exponentiation. It uses the same valid/busy/error handshake as `modular_inverse`, so the two blocks can be chained.

## Interface
- `WIDTH`, default 512: operand and modulus width in bits.
- `clk_in`  input  1  system clock; all logic is on the rising edge.
- `rst_in`  input  1  synchronous, active-low reset.
- `a_in`  input  WIDTH  multiplicand; must satisfy a_in < n_in.
- `b_in`  input  WIDTH  multiplier; any value is accepted.
- `n_in`  input  WIDTH  modulus; must be non-zero.
- `valid_in`  input  1  start strobe, single cycle.
- `c_out`  output  WIDTH  result (a·b) mod n.
- `valid_out`  output  1  one-cycle pulse marking c_out/error_out as valid.
- `busy_out`  output  1  high while an operation is in progress.
- `error_out`  output  1  operand error, qualified by valid_out.

## Operation
- Reset: the block is held in reset while rst_in = 0 at a clock edge.
  - State goes to IDLE.
  - c_out = 0, valid_out = 0, busy_out = 0, error_out = 0.
  - All internal registers are cleared.
- States: IDLE → RUN → DONE → IDLE, plus IDLE → ERR → IDLE.
- IDLE: when valid_in = 1, capture a_in, b_in and n_in into registers.
  - If n_in = 0 or a_in ≥ n_in, go to ERR.
  - Otherwise go to RUN with r = 0 and bit index i = WIDTH−1.
- RUN: each cycle performs one step.
  - t = 2r; if t ≥ n, t = t − n.
  - If b[i] = 1: t = t + a; if t ≥ n, t = t − n.
  - r ← t, then i ← i − 1.
  - After the step with i = 0, go to DONE.
- Invariant: r < n at all times. Intermediates are WIDTH+1 bits wide, and one conditional subtraction per add is sufficient.
- DONE: c_out ← r, valid_out = 1 and error_out = 0 for one cycle, then return to IDLE.
- ERR: c_out ← 0, valid_out = 1 and error_out = 1 for one cycle, then return to IDLE.
- valid_in is ignored in every state except IDLE. There is no queuing.
- Inputs are only sampled on the acceptance edge. Changes to a_in, b_in or n_in afterwards have no effect on the operation in progress.
- n = 1 is legal: a must be 0 and the result is 0.
- c_out holds its last value until the next DONE, ERR or reset.

## Timing
- Acceptance: valid_in is high at edge k while the state is IDLE.
- Normal operation:
  - RUN occupies edges k+1 … k+WIDTH.
  - valid_out is high during the cycle after edge k+WIDTH.
  - Latency from acceptance to valid_out is WIDTH+1 cycles (513 for WIDTH=512).
- Error operation: valid_out and error_out are high during the cycle after edge k+1 (latency 2).
- busy_out is high from the cycle after acceptance through the cycle in which valid_out is high. It is low in IDLE.
- Back-to-back operation: a new valid_in is accepted on the edge immediately after the valid_out cycle. The minimum spacing between starts is WIDTH+2 cycles.
- Reset mid-operation: the operation is aborted and no valid_out is produced. Outputs follow the reset values on the next cycle.
- Simultaneous valid_in and reset: reset wins, and the request is dropped.
- Critical path: one WIDTH+1-bit add and compare per stage, two stages chained per cycle. No pipelining is required at 100 MHz.

## Structure
- Package `mod_arith_pkg`, shared with `modular_inverse`, holds:
  - the state enum: IDLE, RUN, DONE, ERR;
  - localparam `MOD_DEFAULT_WIDTH = 512`.
- Sub-module `mod_add_reduce #(WIDTH)` is combinational: it computes (x + y) mod n for x, y < n.
  - It is instantiated twice per RUN step: once for the doubling (x = y = r) and once for the conditional add (y = a or 0).
- The bit index counter is $clog2(WIDTH) bits wide.

## Test plan
- WIDTH=8, a=3, b=5, n=7:
  - c_out = 1 with error_out = 0.
  - valid_out arrives exactly 9 cycles after acceptance.
  - busy_out is high for 9 cycles.
- WIDTH=8, a=250, b=250, n=251:
  - c_out = 1, exercising the full-range reduction.
  - Then a=0, b=255, n=251 gives c_out = 0.
- Error cases, WIDTH=8:
  - n=0 gives error_out = 1, valid_out 2 cycles after acceptance, c_out = 0.
  - a=9, n=7 gives the same error response.
  - A following a=2, b=4, n=7 gives c_out = 1.
- Ignored start: assert valid_in while busy → no effect.
- Reset mid-operation: pull rst_in low at cycle 4 of RUN.
  - No valid_out is produced and all outputs read 0.
  - A restarted a=3, b=5, n=7 still gives c_out = 1.
- Full-width consistency, WIDTH=512: take the golden 512-bit `modular_inverse` vector with a = its reduced inverse output, b = its input and n = its base.
  - c_out = 1, with valid_out at cycle 513.
  - With b = 1, c_out = a.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic blocks
// (modular_multiply, modular_inverse).
package mod_arith_pkg;

  localparam int MOD_DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/modular_multiply_if.sv
// Start/result handshake bundle for the modular multiplier.
// master drives operands and the start strobe.
interface modular_multiply_if #(
  parameter int WIDTH = mod_arith_pkg::MOD_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] n_in;
  logic             valid_in;
  logic [WIDTH-1:0] c_out;
  logic             valid_out;
  logic             busy_out;
  logic             error_out;

  modport master (
    output a_in,
    output b_in,
    output n_in,
    output valid_in,
    input  c_out,
    input  valid_out,
    input  busy_out,
    input  error_out
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  n_in,
    input  valid_in,
    output c_out,
    output valid_out,
    output busy_out,
    output error_out
  );

endinterface

// File: rtl/mod_add_reduce.sv
// Combinational (x + y) mod n for x, y < n.
// One extra bit holds the carry so one subtract suffices.
module mod_add_reduce #(
  parameter int WIDTH = mod_arith_pkg::MOD_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] red;

  assign sum = {1'b0, x} + {1'b0, y};
  assign red = sum - {1'b0, n};
  assign s   = (sum >= {1'b0, n}) ? red[WIDTH-1:0]
                                  : sum[WIDTH-1:0];

endmodule

// File: rtl/modular_multiply.sv
// Interleaved MSB-first modular multiplier:
// one multiplier bit per clock, c = (a * b) mod n.
module modular_multiply
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = MOD_DEFAULT_WIDTH
) (
  input logic               clk_in,
  input logic               rst_in,
  modular_multiply_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e state;
  state_e state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] c_q;
  logic [IW-1:0]    idx_q;
  logic             pend_q;

  logic [WIDTH-1:0] dbl;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] step;
  logic             bad;
  logic             last;

  assign bad  = (bus.n_in == '0) ||
                (bus.a_in >= bus.n_in);
  assign last = (idx_q == '0);

  assign addend = b_q[idx_q] ? a_q : '0;

  mod_add_reduce #(.WIDTH(WIDTH)) u_dbl (
    .x (r_q),
    .y (r_q),
    .n (n_q),
    .s (dbl)
  );

  mod_add_reduce #(.WIDTH(WIDTH)) u_add (
    .x (dbl),
    .y (addend),
    .n (n_q),
    .s (step)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.valid_in) state_nx = bad ? ERR : RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      ERR:  if (!pend_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ERR spends one settle cycle (pend_q) before its pulse
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.valid_in) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            n_q    <= bus.n_in;
            r_q    <= '0;
            idx_q  <= IW'(WIDTH - 1);
            pend_q <= bad;
            if (bad) c_q <= '0;
          end
        end
        RUN: begin
          r_q   <= step;
          idx_q <= idx_q - IW'(1);
          if (last) c_q <= step;
        end
        ERR: pend_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.c_out     = c_q;
  assign bus.busy_out  = (state != IDLE);
  assign bus.error_out = (state == ERR) && !pend_q;
  assign bus.valid_out = (state == DONE) ||
                         bus.error_out;

endmodule
